// File: rtl/noc_bridge_vc.sv
// noc_bridge_vc: buffers flits from a router output port in a first-word
// fall-through FIFO and steers each packet, whole and in order, to one of
// NUM_CH sender channels. The header flit carries the channel number.
// Packets with an out-of-range channel are dropped, and so are flits that
// arrive outside a packet. Both cases are counted in drop_cnt.
//
// Handshake: a flit moves on a rising edge where valid && ready are both
// high on the same port. Once valid is high it stays high with the same
// flit until that transfer. The one exception is a header waiting in IDLE,
// which is withdrawn if the target channel's VCready goes low.
module noc_bridge_vc #(
  parameter int DATA_W    = 32,
  parameter int NUM_CH    = 4,
  parameter int DEPTH     = 8,
  parameter int SEL_LSB   = 0,
  parameter int VC_THRESH = 2
) (
  input  logic                     noc_clk,
  input  logic                     rst_n,
  input  logic                     Noc_receive_valid,
  output logic                     Noc_receive_ready,
  input  logic [DATA_W-1:0]        Noc_receive_flit,
  output logic                     Noc_receive_VCready,
  input  logic                     Noc_receive_is_header,
  input  logic                     Noc_receive_is_tail,
  output logic [NUM_CH-1:0]        Noc_sender_valid,
  input  logic [NUM_CH-1:0]        Noc_sender_ready,
  output logic [NUM_CH*DATA_W-1:0] Noc_sender_flit,
  input  logic [NUM_CH-1:0]        Noc_sender_VCready,
  output logic [NUM_CH-1:0]        Noc_sender_is_header,
  output logic [NUM_CH-1:0]        Noc_sender_is_tail,
  output logic [7:0]               drop_cnt,
  output logic [1:0]               dbg_state
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = DATA_W + 2;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DROP = 2'd2
  } state_t;

  // Each FIFO entry is {is_header, is_tail, flit}.
  logic [ENT_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic [PTR_W:0]    free_cnt;
  logic              wr_en;
  logic              rd_en;
  logic              empty;

  logic [ENT_W-1:0]  head;
  logic [DATA_W-1:0] head_flit;
  logic              head_hdr;
  logic              head_tail;
  logic [CH_W-1:0]   sel;
  logic              sel_bad;

  state_t            state;
  state_t            state_nxt;
  logic [CH_W-1:0]   cur_ch;
  logic [CH_W-1:0]   ch_nxt;
  logic              drop_inc;
  logic [NUM_CH-1:0] valid_vec;

  assign empty     = (count == '0);
  assign free_cnt  = DEPTH_C - count;
  assign wr_en     = Noc_receive_valid && Noc_receive_ready;
  assign head      = mem[rd_ptr];
  assign head_hdr  = head[DATA_W+1];
  assign head_tail = head[DATA_W];
  assign head_flit = head[DATA_W-1:0];
  assign sel       = head_flit[SEL_LSB +: CH_W];
  assign sel_bad   = (int'(sel) >= NUM_CH);

  // Receive-side flow control comes straight from the count register, so a
  // slot freed by a read in a full cycle only reopens ready on the next one.
  assign Noc_receive_ready   = (count != DEPTH_C);
  assign Noc_receive_VCready = (int'(free_cnt) >= VC_THRESH);

  // FIFO storage; contents need no reset because count gates every use.
  always_ff @(posedge noc_clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= {Noc_receive_is_header, Noc_receive_is_tail, Noc_receive_flit};
    end
  end

  // FIFO pointers and occupancy; pointers wrap modulo DEPTH.
  always_ff @(posedge noc_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Steering state, locked channel and saturating drop counter.
  always_ff @(posedge noc_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cur_ch   <= '0;
      drop_cnt <= '0;
    end else begin
      state  <= state_nxt;
      cur_ch <= ch_nxt;
      if (drop_inc && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // Next state, pops and per-channel valid from the FIFO head.
  always_comb begin
    state_nxt = state;
    ch_nxt    = cur_ch;
    rd_en     = 1'b0;
    drop_inc  = 1'b0;
    valid_vec = '0;
    case (state)
      IDLE: begin
        if (!empty) begin
          if (!head_hdr) begin
            // Flit outside any packet: discard it as a one-flit drop.
            rd_en    = 1'b1;
            drop_inc = 1'b1;
          end else if (sel_bad) begin
            rd_en    = 1'b1;
            drop_inc = 1'b1;
            if (!head_tail) state_nxt = DROP;
          end else begin
            // A new packet may only start on a channel that has VC space.
            for (int c = 0; c < NUM_CH; c++) begin
              if (int'(sel) == c) valid_vec[c] = Noc_sender_VCready[c];
            end
            if (|(valid_vec & Noc_sender_ready)) begin
              rd_en  = 1'b1;
              ch_nxt = sel;
              if (!head_tail) state_nxt = SEND;
            end
          end
        end
      end
      SEND: begin
        // Mid-packet the header flag is ignored; only the tail ends it.
        for (int c = 0; c < NUM_CH; c++) begin
          if (int'(cur_ch) == c) valid_vec[c] = !empty;
        end
        if (|(valid_vec & Noc_sender_ready)) begin
          rd_en = 1'b1;
          if (head_tail) state_nxt = IDLE;
        end
      end
      DROP: begin
        if (!empty) begin
          rd_en = 1'b1;
          if (head_tail) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign Noc_sender_valid     = valid_vec;
  assign Noc_sender_flit      = {NUM_CH{head_flit}};
  assign Noc_sender_is_header = valid_vec & {NUM_CH{head_hdr}};
  assign Noc_sender_is_tail   = valid_vec & {NUM_CH{head_tail}};
  assign dbg_state            = state;

endmodule
